// File: rtl/control_unit.sv
// control_unit: FETCH/EXEC1/EXEC2/HALT sequencer for an accumulator CPU; define CONTROL_UNIT_LDX_EN to enable indexed LDX (opcode 9).
module control_unit #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [OPCODE_W-1:0] IR_IN,
  input  logic                MEM_READY,
  input  logic                START,
  input  logic                EQ,
  input  logic                MI,
  output logic                FETCH,
  output logic                EXEC1,
  output logic                EXEC2,
  output logic                HALTED,
  output logic                IR_LOAD,
  output logic                EXTRA,
  output logic                Wren,
  output logic                MUX1,
  output logic                MUX3,
  output logic                MUX3_useAllBits,
  output logic                IDX_SEL,
  output logic                PC_sload,
  output logic                PC_cnt_en,
  output logic                ACC_EN,
  output logic                ACC_LOAD,
  output logic                ACC_SHIFTIN,
  output logic                ADDSUB,
  output logic                ILLEGAL,
  output logic [CNT_W-1:0]    INSTR_COUNT
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC1, S_EXEC2, S_HALT} state_t;
  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          op;
  logic                hi_bits, retire;
  logic                op_lda, op_sta, op_add, op_sub, op_jmp, op_jmi, op_jeq, op_stp, op_ldi, op_ldx, op_bad;
  assign op      = ir_q[3:0];
  assign hi_bits = (ir_q >> 4) != '0;
  assign op_lda  = !hi_bits && op == 4'd0;
  assign op_sta  = !hi_bits && op == 4'd1;
  assign op_add  = !hi_bits && op == 4'd2;
  assign op_sub  = !hi_bits && op == 4'd3;
  assign op_jmp  = !hi_bits && op == 4'd4;
  assign op_jmi  = !hi_bits && op == 4'd5;
  assign op_jeq  = !hi_bits && op == 4'd6;
  assign op_stp  = !hi_bits && op == 4'd7;
  assign op_ldi  = !hi_bits && op == 4'd8;
`ifdef CONTROL_UNIT_LDX_EN
  assign op_ldx  = !hi_bits && op == 4'd9;
`else
  assign op_ldx  = 1'b0;
`endif
  assign op_bad  = !(op_lda | op_sta | op_add | op_sub | op_jmp | op_jmi | op_jeq | op_stp | op_ldi | op_ldx);
  assign FETCH       = state_q == S_FETCH;
  assign EXEC1       = state_q == S_EXEC1;
  assign EXEC2       = state_q == S_EXEC2;
  assign HALTED      = state_q == S_HALT;
  assign ACC_SHIFTIN = 1'b0;
  assign INSTR_COUNT = cnt_q;
  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    IR_LOAD         = 1'b0;
    EXTRA           = 1'b0;
    Wren            = 1'b0;
    MUX1            = 1'b0;
    MUX3            = 1'b0;
    MUX3_useAllBits = 1'b0;
    IDX_SEL         = 1'b0;
    PC_sload        = 1'b0;
    PC_cnt_en       = 1'b0;
    ACC_EN          = 1'b0;
    ACC_LOAD        = 1'b0;
    ADDSUB          = 1'b0;
    ILLEGAL         = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IR_LOAD = MEM_READY & RESET_N;
        ir_d    = MEM_READY ? IR_IN : ir_q;
        state_d = MEM_READY ? S_EXEC1 : S_FETCH;
      end
      S_EXEC1: begin
        EXTRA     = op_lda | op_add | op_sub | op_ldx;
        MUX1      = op_lda | op_add | op_sub | op_ldx | op_sta;
        IDX_SEL   = op_ldx;
        Wren      = op_sta;
        PC_sload  = op_jmp | (op_jmi & MI) | (op_jeq & EQ);
        PC_cnt_en = op_sta | (op_jmi & !MI) | (op_jeq & !EQ) | op_ldi | op_bad;
        MUX3      = op_ldi;
        ACC_EN    = op_ldi;
        ACC_LOAD  = op_ldi;
        ILLEGAL   = op_bad;
        state_d   = EXTRA ? S_EXEC2 : op_stp ? S_HALT : S_FETCH;
      end
      S_EXEC2: begin
        MUX3            = op_lda | op_ldx;
        MUX3_useAllBits = op_lda | op_ldx;
        ACC_EN          = MEM_READY;
        ACC_LOAD        = MEM_READY;
        PC_cnt_en       = MEM_READY;
        ADDSUB          = op_add & MEM_READY;
        state_d         = MEM_READY ? S_FETCH : S_EXEC2;
      end
      S_HALT: state_d = START ? S_FETCH : S_HALT;
    endcase
  end
  // an instruction retires when it leaves EXEC1/EXEC2 for FETCH, or when STP parks in HALT
  assign retire = (state_d == S_FETCH && (state_q == S_EXEC1 || state_q == S_EXEC2)) ||
                  (state_d == S_HALT && state_q != S_HALT);
  assign cnt_d  = (retire && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
